line_memory: RTL and testbench



---
 rtl/line_memory.sv | 105 ++++++++++
 tb/tb_line_memory.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/line_memory.sv
// line_memory: 256-bit line backing store with a fixed request-to-ack latency (IDLE/WAIT/ACK).
// Optional LINE_MEMORY_STATS_EN adds read/write completion counters. Rev 1.0
`default_nettype none

module line_memory #(
   parameter int DEPTH   = 512,
   parameter int LATENCY = 10,
   parameter int LINE_W  = 256
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              mem_enable_i,
   input  logic              mem_write_i,
   input  logic [31:0]       mem_addr_i,
   input  logic [LINE_W-1:0] mem_data_i,
   output logic              mem_ack_o,
   output logic [LINE_W-1:0] mem_data_o,
   output logic              busy_o
`ifdef LINE_MEMORY_STATS_EN
   ,
   output logic [31:0]       rd_count_o,
   output logic [31:0]       wr_count_o
`endif
);

   localparam int IDX_W = $clog2(DEPTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ACK  = 2'd2
   } state_t;

   state_t              state;
   state_t              state_next;
   logic [7:0]          cnt;
   logic [IDX_W-1:0]    idx_q;
   logic                write_q;
   logic [LINE_W-1:0]   data_q;
   logic [LINE_W-1:0]   mem [DEPTH];
   logic                access;
   logic                unused_addr_bits;

   // Offset and high address bits are dropped, so addresses alias modulo DEPTH.
   assign unused_addr_bits = ^{mem_addr_i[31:5+IDX_W], mem_addr_i[4:0]};

   assign access    = (state == WAIT) && (cnt == 8'(LATENCY));
   assign mem_ack_o = (state == ACK);
   assign busy_o    = (state != IDLE);

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (mem_enable_i) state_next = WAIT;
         WAIT:    if (access) state_next = ACK;
         ACK:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_next;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt        <= 8'd0;
         idx_q      <= '0;
         write_q    <= 1'b0;
         data_q     <= '0;
         mem_data_o <= '0;
      end else begin
         if (state == IDLE && mem_enable_i) begin
            cnt     <= 8'd1;
            idx_q   <= mem_addr_i[5+IDX_W-1:5];
            write_q <= mem_write_i;
            data_q  <= mem_data_i;
         end else if (state == WAIT && !access) begin
            cnt <= cnt + 8'd1;
         end
         if (access && !write_q) mem_data_o <= mem[idx_q];
      end
   end

   // Array is not reset; a reset coinciding with the access edge discards the write.
   always_ff @(posedge clk_i) begin
      if (!rst_i && access && write_q) mem[idx_q] <= data_q;
   end

`ifdef LINE_MEMORY_STATS_EN
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_count_o <= 32'd0;
         wr_count_o <= 32'd0;
      end else if (access) begin
         if (write_q) wr_count_o <= wr_count_o + 32'd1;
         else         rd_count_o <= rd_count_o + 32'd1;
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_line_memory.sv
// tb_line_memory: directed scoreboard bench for line_memory (LATENCY=10 and LATENCY=1 instances).
// Rev 1.0
`default_nettype none

module tb_line_memory;

   localparam int LAT = 10;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         en = 1'b0, wr = 1'b0;
   logic [31:0]  addr = '0;
   logic [255:0] wdata = '0;
   logic         ack, busy;
   logic [255:0] rdata;

   logic         en1 = 1'b0, wr1 = 1'b0;
   logic [31:0]  addr1 = '0;
   logic [255:0] wdata1 = '0;
   logic         ack1, busy1;
   logic [255:0] rdata1;
`ifdef LINE_MEMORY_STATS_EN
   logic [31:0]  rdc, wrc, rdc1, wrc1;
`endif

   int vectors = 0;
   int miscompares = 0;
   logic [255:0] model [512];
   logic [255:0] exp_q [$];
   logic [255:0] last_rd;

   always #5 clk = ~clk;

   line_memory #(.DEPTH(512), .LATENCY(LAT), .LINE_W(256)) dut (
      .clk_i(clk), .rst_i(rst), .mem_enable_i(en), .mem_write_i(wr),
      .mem_addr_i(addr), .mem_data_i(wdata), .mem_ack_o(ack),
      .mem_data_o(rdata), .busy_o(busy)
`ifdef LINE_MEMORY_STATS_EN
      , .rd_count_o(rdc), .wr_count_o(wrc)
`endif
   );

   line_memory #(.DEPTH(512), .LATENCY(1), .LINE_W(256)) dut1 (
      .clk_i(clk), .rst_i(rst), .mem_enable_i(en1), .mem_write_i(wr1),
      .mem_addr_i(addr1), .mem_data_i(wdata1), .mem_ack_o(ack1),
      .mem_data_o(rdata1), .busy_o(busy1)
`ifdef LINE_MEMORY_STATS_EN
      , .rd_count_o(rdc1), .wr_count_o(wrc1)
`endif
   );

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One request on the LATENCY=10 instance; the edge after the driving negedge is edge k,
   // and iteration n samples just after edge k+n.
   task automatic do_req(input bit w, input logic [31:0] a, input logic [255:0] d, input bit toggle);
      int idx;
      idx = int'(a[13:5]);
      @(negedge clk);
      en = 1'b1; wr = w; addr = a; wdata = d;
      if (w) model[idx] = d;
      else   exp_q.push_back(model[idx]);
      for (int n = 0; n <= LAT + 2; n++) begin
         @(negedge clk);
         check($sformatf("busy n=%0d", n), 256'(busy), 256'(n <= LAT));
         check($sformatf("ack n=%0d", n), 256'(ack), 256'(n == LAT));
         if (n == LAT && !w) last_rd = exp_q.pop_front();
         if (n >= LAT) check($sformatf("rdata n=%0d", n), rdata, last_rd);
         if (toggle && n <= LAT) begin
            en    = 1'($urandom);
            wr    = 1'($urandom);
            addr  = $urandom;
            wdata = {8{$urandom}};
         end else begin
            en = 1'b0; wr = 1'b0;
         end
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("reset ack", 256'(ack), 256'(0));
      check("reset busy", 256'(busy), 256'(0));
      check("reset rdata", rdata, 256'(0));
      check("reset busy1", 256'(busy1), 256'(0));
      last_rd = '0;
      rst = 1'b0;

      // Known contents for lines 0 and 3
      do_req(1'b1, 32'h0000_0000, {8{32'h0123_4567}}, 1'b0);
      do_req(1'b1, 32'h0000_0060, {8{32'hA5A5_5A5A}}, 1'b0);

      do_req(1'b1, 32'h0000_0040, {8{32'hDEAD_BEEF}}, 1'b0);
      do_req(1'b0, 32'h0000_0040, '0, 1'b0);
      do_req(1'b0, 32'h0000_4040, '0, 1'b0);
      do_req(1'b0, 32'h0000_005F, '0, 1'b0);
      check("alias line2", last_rd, {8{32'hDEAD_BEEF}});

      do_req(1'b0, 32'h0000_0000, '0, 1'b1);
      do_req(1'b0, 32'h0000_0000, '0, 1'b0);
      check("line0 intact", last_rd, {8{32'h0123_4567}});

      // Write to line 3 aborted by reset at edge k+5
      @(negedge clk);
      en = 1'b1; wr = 1'b1; addr = 32'h0000_0060; wdata = '1;
      for (int n = 0; n <= 4; n++) begin
         @(negedge clk);
         en = 1'b0;
         check($sformatf("abort ack n=%0d", n), 256'(ack), 256'(0));
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      last_rd = '0;
      check("abort busy", 256'(busy), 256'(0));
      check("abort rdata", rdata, 256'(0));
      for (int n = 0; n < LAT; n++) begin
         @(negedge clk);
         check($sformatf("abort noack %0d", n), 256'(ack), 256'(0));
      end
      do_req(1'b0, 32'h0000_0060, '0, 1'b0);

      // Reset and enable together: request dropped
      @(negedge clk);
      rst = 1'b1; en = 1'b1; wr = 1'b0; addr = 32'h0000_0040;
      @(negedge clk);
      rst = 1'b0; en = 1'b0;
      check("rst+en busy", 256'(busy), 256'(0));
      last_rd = '0;
      @(negedge clk);
      check("rst+en busy2", 256'(busy), 256'(0));

      // LATENCY=1 instance: prime line 1, then back-to-back read/write with enable held
      @(negedge clk);
      en1 = 1'b1; wr1 = 1'b1; addr1 = 32'h0000_0020; wdata1 = {8{32'hCAFE_F00D}};
      @(negedge clk);
      en1 = 1'b0;
      @(negedge clk);
      check("l1 prime ack", 256'(ack1), 256'(1));
      @(negedge clk);
      check("l1 prime idle", 256'(busy1), 256'(0));

      en1 = 1'b1; wr1 = 1'b0; addr1 = 32'h0000_0020;
      exp_q.push_back({8{32'hCAFE_F00D}});
      for (int n = 0; n <= 5; n++) begin
         @(negedge clk);
         check($sformatf("l1 ack n=%0d", n), 256'(ack1), 256'(n == 1 || n == 4));
         check($sformatf("l1 busy n=%0d", n), 256'(busy1), 256'(n != 2 && n != 5));
         if (n == 0) begin wr1 = 1'b1; addr1 = 32'h0000_0040; wdata1 = {8{32'h1357_9BDF}}; end
         if (n == 1) check("l1 rdata", rdata1, exp_q.pop_front());
         if (n == 3) en1 = 1'b0;
      end

      en1 = 1'b1; wr1 = 1'b0; addr1 = 32'h0000_0040;
      exp_q.push_back({8{32'h1357_9BDF}});
      @(negedge clk);
      en1 = 1'b0;
      @(negedge clk);
      check("l1 rd2 ack", 256'(ack1), 256'(1));
      check("l1 rd2 data", rdata1, exp_q.pop_front());
`ifdef LINE_MEMORY_STATS_EN
      check("l1 rd_count", 256'(rdc1), 256'(2));
      check("l1 wr_count", 256'(wrc1), 256'(2));
      check("rd_count", 256'(rdc), 256'(0));
      check("wr_count", 256'(wrc), 256'(0));
`endif
      repeat (2) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
